// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: serializer state encoding,
// control/status register bit positions and the default bus addresses.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

  // Control/status register bit positions
  localparam int CON_IRQ_EN  = 0;
  localparam int CON_OVF     = 1;
  localparam int CON_DONE    = 2;
  localparam int CON_FULL    = 3;
  localparam int CON_BUSY    = 4;
  localparam int CON_CNT_LSB = 5;
  localparam int CON_CNT_MSB = 7;

  // Default register addresses, shared with the receive side and MEM decode
  localparam logic [31:0] UART_TXD_ADDR = 32'h4000_0018;
  localparam logic [31:0] UART_CON_ADDR = 32'h4000_0020;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and occupancy count.
// The head entry is presented combinationally on rdata.
// A push while full or a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Storage array, written on an accepted push (no reset needed for data)
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_responder.sv
// Memory-mapped 8N1 UART transmitter. Stores to TXD queue bytes in a FIFO,
// the serializer drains them back to back, and CON reports status and
// controls the level interrupt.
//
// Bus handshake: mem_write / mem_read are single-cycle strobes with no
// back-pressure; the responder is always ready. A store takes effect at the
// clock edge where the strobe is high; a load returns data on rdata the
// cycle after its strobe, and rdata holds between loads.
module uart_tx_responder
  import uart_pkg::*;
#(
  parameter int          BAUD_DIV   = 5208,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] TXD_ADDR   = UART_TXD_ADDR,
  parameter logic [31:0] CON_ADDR   = UART_CON_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_write,
  input  logic        mem_read,
  output logic [31:0] rdata,
  output logic        uart_txd,
  output logic        tx_irq
);

  localparam int            BW          = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_RELOAD = BW'(BAUD_DIV - 1);
  localparam int            CW          = $clog2(FIFO_DEPTH) + 1;

  tx_state_e     state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          bit_end;

  logic          irq_en;
  logic          ovf_flag;
  logic          done_flag;

  logic          sel_txd;
  logic          sel_con;
  logic          wr_txd;
  logic          wr_con;
  logic          ovf_set;
  logic          done_set;
  logic          busy;
  logic [31:0]   con_value;

  logic          fifo_pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic          unused_bits;
  assign unused_bits = ^{addr[1:0], wdata[31:8]};

  // Word-address decode; the byte offset bits are ignored
  assign sel_txd = (addr[31:2] == TXD_ADDR[31:2]);
  assign sel_con = (addr[31:2] == CON_ADDR[31:2]);
  assign wr_txd  = mem_write && sel_txd;
  assign wr_con  = mem_write && sel_con;
  assign ovf_set = wr_txd && fifo_full;

  assign bit_end  = (baud_cnt == '0);
  assign done_set = (state == ST_STOP) && bit_end;
  assign busy     = (state != ST_IDLE) || !fifo_empty;

  // The serializer takes the head byte when idle, or at the end of a stop
  // bit so consecutive frames leave no idle gap
  assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || done_set);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_txd),
    .pop   (fifo_pop),
    .wdata (wdata[7:0]),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Assemble the CON read value; count is reported in a 3-bit field
  always_comb begin
    con_value = '0;
    con_value[CON_IRQ_EN] = irq_en;
    con_value[CON_OVF]    = ovf_flag;
    con_value[CON_DONE]   = done_flag;
    con_value[CON_FULL]   = fifo_full;
    con_value[CON_BUSY]   = busy;
    con_value[CON_CNT_MSB:CON_CNT_LSB] = 3'(fifo_count);
  end

  // Serializer FSM; the line level is registered together with the state
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      uart_txd  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          uart_txd <= 1'b1;
          if (!fifo_empty) begin
            shift_reg <= fifo_head;
            baud_cnt  <= BAUD_RELOAD;
            uart_txd  <= 1'b0;
            state     <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            bit_idx  <= '0;
            uart_txd <= shift_reg[0];
            state    <= ST_DATA;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              uart_txd <= 1'b1;
              state    <= ST_STOP;
            end else begin
              shift_reg <= {1'b0, shift_reg[7:1]};
              bit_idx   <= bit_idx + 1'b1;
              uart_txd  <= shift_reg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= BAUD_RELOAD;
            if (!fifo_empty) begin
              shift_reg <= fifo_head;
              uart_txd  <= 1'b0;
              state     <= ST_START;
            end else begin
              uart_txd <= 1'b1;
              state    <= ST_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: begin
          uart_txd <= 1'b1;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  // Control bits, sticky flags (software clear beats a same-cycle set) and IRQ
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_en    <= 1'b0;
      ovf_flag  <= 1'b0;
      done_flag <= 1'b0;
      tx_irq    <= 1'b0;
    end else begin
      if (wr_con) irq_en <= wdata[CON_IRQ_EN];

      if (wr_con && wdata[CON_OVF]) ovf_flag <= 1'b0;
      else if (ovf_set)             ovf_flag <= 1'b1;

      if (wr_con && wdata[CON_DONE]) done_flag <= 1'b0;
      else if (done_set)             done_flag <= 1'b1;

      tx_irq <= irq_en && (done_flag || ovf_flag);
    end
  end

  // Registered read port; holds its value when no load is presented
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (mem_read) begin
      if (sel_con) rdata <= con_value;
      else         rdata <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_responder.sv
// Directed bench for uart_tx_responder with BAUD_DIV=4, FIFO_DEPTH=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_uart_tx_responder;

  localparam logic [31:0] TXD = 32'h4000_0018;
  localparam logic [31:0] CON = 32'h4000_0020;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] rdata;
  logic        uart_txd;
  logic        tx_irq;

  int vectors;
  int miscompares;

  uart_tx_responder #(
    .BAUD_DIV   (4),
    .FIFO_DEPTH (4),
    .TXD_ADDR   (TXD),
    .CON_ADDR   (CON)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .rdata     (rdata),
    .uart_txd  (uart_txd),
    .tx_irq    (tx_irq)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    mem_write = 1'b0;
    mem_read  = 1'b0;
    addr      = '0;
    wdata     = '0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr      = a;
    wdata     = d;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr     = a;
    mem_read = 1'b1;
    tick();
    mem_read = 1'b0;
    d = rdata;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    vectors++;
    if (uart_txd !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_txd: got %b expected 1", uart_txd);
    end
    vectors++;
    if (tx_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_irq: got %b expected 0", tx_irq);
    end
    vectors++;
    if (rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h expected 0", rdata);
    end
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_con: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_single_frame();
    logic [31:0] rd;
    logic [9:0]  frame;
    logic        exp_bit;
    do_reset();
    bus_write(TXD, 32'h0000_0055);
    tick();
    frame = {1'b1, 8'h55, 1'b0};
    for (int t = 0; t < 40; t++) begin
      exp_bit = frame[t/4];
      vectors++;
      if (uart_txd !== exp_bit) begin
        miscompares++;
        $display("FAIL single_frame_bit t=%0d: got %b expected %b", t, uart_txd, exp_bit);
      end
      vectors++;
      if (tx_irq !== 1'b0) begin
        miscompares++;
        $display("FAIL single_irq_off t=%0d: got %b expected 0", t, tx_irq);
      end
      tick();
    end
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0000_0004) begin
      miscompares++;
      $display("FAIL single_done_con: got %h expected 00000004", rd);
    end
    // enabling the interrupt with done already set raises tx_irq a cycle later
    bus_write(CON, 32'h0000_0001);
    vectors++;
    if (tx_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL done_irq_early: got %b expected 0", tx_irq);
    end
    tick();
    vectors++;
    if (tx_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL done_irq_set: got %b expected 1", tx_irq);
    end
    bus_write(CON, 32'h0000_0004);
    vectors++;
    if (tx_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL done_irq_hold: got %b expected 1", tx_irq);
    end
    tick();
    vectors++;
    if (tx_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL done_irq_clear: got %b expected 0", tx_irq);
    end
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL done_clear_con: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0]  b2b [5];
    logic [9:0]  frame;
    logic        exp_bit;
    int          bit_no;
    b2b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    do_reset();
    for (int i = 0; i < 5; i++) bus_write(TXD, {24'h0, b2b[i]});
    // the first frame started at the edge after the first store (t=0)
    for (int t = 3; t < 200; t++) begin
      bit_no  = t / 4;
      frame   = {1'b1, b2b[bit_no/10], 1'b0};
      exp_bit = frame[bit_no%10];
      vectors++;
      if (uart_txd !== exp_bit) begin
        miscompares++;
        $display("FAIL b2b_bit t=%0d: got %b expected %b", t, uart_txd, exp_bit);
      end
      tick();
    end
    vectors++;
    if (uart_txd !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_idle: got %b expected 1", uart_txd);
    end
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0000_0004) begin
      miscompares++;
      $display("FAIL b2b_con: got %h expected 00000004", rd);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    do_reset();
    bus_write(CON, 32'h0000_0001);
    for (int i = 0; i < 6; i++) bus_write(TXD, 32'h10 + i);
    vectors++;
    if (tx_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_irq_early: got %b expected 0", tx_irq);
    end
    tick();
    vectors++;
    if (tx_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_irq_set: got %b expected 1", tx_irq);
    end
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0000_009B) begin
      miscompares++;
      $display("FAIL ovf_con: got %h expected 0000009b", rd);
    end
    bus_write(CON, 32'h0000_0002);
    vectors++;
    if (tx_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_irq_hold: got %b expected 1", tx_irq);
    end
    tick();
    vectors++;
    if (tx_irq !== 1'b0) begin
      miscompares++;
      $display("FAIL ovf_irq_clear: got %b expected 0", tx_irq);
    end
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0000_0098) begin
      miscompares++;
      $display("FAIL ovf_cleared_con: got %h expected 00000098", rd);
    end
    tick();
    vectors++;
    if (rdata !== 32'h0000_0098) begin
      miscompares++;
      $display("FAIL rdata_hold: got %h expected 00000098", rdata);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    logic [9:0]  frame;
    logic        exp_bit;
    do_reset();
    bus_write(TXD, 32'h0000_00A3);
    for (int i = 0; i < 17; i++) tick();
    // data bit 3 of 0xA3 is on the line here
    vectors++;
    if (uart_txd !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_frame_bit: got %b expected 0", uart_txd);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++;
    if (uart_txd !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_txd: got %b expected 1", uart_txd);
    end
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL abort_con: got %h expected 00000000", rd);
    end
    for (int t = 0; t < 44; t++) begin
      vectors++;
      if (uart_txd !== 1'b1) begin
        miscompares++;
        $display("FAIL abort_quiet t=%0d: got %b expected 1", t, uart_txd);
      end
      tick();
    end
    bus_write(TXD, 32'h0000_003C);
    tick();
    frame = {1'b1, 8'h3C, 1'b0};
    for (int t = 0; t < 40; t++) begin
      exp_bit = frame[t/4];
      vectors++;
      if (uart_txd !== exp_bit) begin
        miscompares++;
        $display("FAIL post_reset_bit t=%0d: got %b expected %b", t, uart_txd, exp_bit);
      end
      tick();
    end
  endtask

  task automatic test_con_busy();
    logic [31:0] rd;
    do_reset();
    bus_write(TXD, 32'h11);
    bus_write(TXD + 32'd2, 32'h22);
    bus_write(TXD, 32'h33);
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0000_0050) begin
      miscompares++;
      $display("FAIL busy_con: got %h expected 00000050", rd);
    end
    bus_read(32'h4000_0024, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL unmapped_read: got %h expected 00000000", rd);
    end
    bus_read(CON + 32'd3, rd);
    vectors++;
    if (rd !== 32'h0000_0050) begin
      miscompares++;
      $display("FAIL con_byte_offset: got %h expected 00000050", rd);
    end
    bus_read(TXD, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL txd_read: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_ignored_stores();
    logic [31:0] rd;
    do_reset();
    bus_write(32'h4000_0024, 32'h0000_00AB);
    addr      = TXD;
    wdata     = 32'h0000_00CD;
    mem_write = 1'b0;
    tick();
    for (int t = 0; t < 20; t++) begin
      vectors++;
      if (uart_txd !== 1'b1) begin
        miscompares++;
        $display("FAIL ignored_line t=%0d: got %b expected 1", t, uart_txd);
      end
      tick();
    end
    bus_read(CON, rd);
    vectors++;
    if (rd !== 32'h0) begin
      miscompares++;
      $display("FAIL ignored_con: got %h expected 00000000", rd);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    mem_write   = 1'b0;
    mem_read    = 1'b0;
    addr        = '0;
    wdata       = '0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_con_busy();
    test_ignored_stores();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
